// File: rtl/bus_uart_tx_peripheral_pkg.sv
// Shared types and constants for the bus-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_BAUD   = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  // A divisor of zero still yields a one-clock bit.
  function automatic logic [15:0] bit_time(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/bus_uart_tx_peripheral_if.sv
// CPU data-bus slave port as seen by the UART peripheral.
interface bus_uart_tx_peripheral_if;
  logic        busSel;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  Byte_Enable;
  logic [31:0] busRData;

  modport master (output busSel, busWe, busAddr, busWData, Byte_Enable,
                  input  busRData);
  modport slave  (input  busSel, busWe, busAddr, busWData, Byte_Enable,
                  output busRData);
endinterface

// File: rtl/bus_uart_tx_peripheral_sync_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/bus_uart_tx_peripheral.sv
// Register bank, TX FIFO and 8N1 serialiser behind a simple CPU bus slave.
// state | meaning
// IDLE  | line high, waiting for tx_en and a queued byte
// START | start bit (0) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1) for one bit time
module bus_uart_tx_peripheral
  import uart_pkg::*;
#(
  parameter int          FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                     clk,
  input  logic                     reset,
  bus_uart_tx_peripheral_if.slave  bus,
  output logic                     tx,
  output logic                     tx_empty_irq
);
  logic             tx_en, overflow;
  logic [15:0]      baud_div;
  logic             wr_en, rd_en, push, push_ok, pop, ovf_clr;
  logic [1:0]       reg_addr;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count, count_next;
  logic [31:0]      status_word;
  logic             unused_bits;

  uart_tx_state_e   state, state_d;
  logic [15:0]      timer, timer_d;
  logic [7:0]       shift, shift_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic             bit_done, busy, tx_d, irq_d;

  assign wr_en    = bus.busSel & bus.busWe;
  assign rd_en    = bus.busSel & ~bus.busWe;
  assign reg_addr = bus.busAddr[3:2];
  assign push     = wr_en & (reg_addr == ADDR_TXDATA) & bus.Byte_Enable[0];
  assign ovf_clr  = wr_en & (reg_addr == ADDR_STATUS) & bus.Byte_Enable[0]
                    & bus.busWData[ST_OVF];
  assign push_ok  = push & (~fifo_full | pop);
  assign unused_bits = ^{bus.busAddr[31:4], bus.busAddr[1:0],
                         bus.busWData[31:16], bus.Byte_Enable[3:2]};

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.busWData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_en    <= 1'b0;
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_en && reg_addr == ADDR_CTRL && bus.Byte_Enable[0]) tx_en <= bus.busWData[0];
      if (wr_en && reg_addr == ADDR_BAUD) begin
        if (bus.Byte_Enable[0]) baud_div[7:0]  <= bus.busWData[7:0];
        if (bus.Byte_Enable[1]) baud_div[15:8] <= bus.busWData[15:8];
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clr)              overflow <= 1'b0;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = busy;
    status_word[ST_OVF]   = overflow;
    status_word[ST_CNT_LSB +: FIFO_AW+1] = fifo_count;
    bus.busRData = '0;
    if (rd_en) begin
      case (reg_addr)
        ADDR_CTRL:   bus.busRData = {31'd0, tx_en};
        ADDR_BAUD:   bus.busRData = {16'd0, baud_div};
        ADDR_STATUS: bus.busRData = status_word;
        default:     bus.busRData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= 16'd1;
      shift        <= '0;
      bit_idx      <= '0;
      tx           <= 1'b1;
      tx_empty_irq <= 1'b1;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      shift        <= shift_d;
      bit_idx      <= bit_idx_d;
      tx           <= tx_d;
      tx_empty_irq <= irq_d;
    end
  end

  assign bit_done = (timer == 16'd1);

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    pop       = 1'b0;
    case (state)
      IDLE: if (tx_en && !fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_dout;
        timer_d = bit_time(baud_div);
        state_d = START;
      end
      START: if (bit_done) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
        timer_d   = bit_time(baud_div);
      end else timer_d = timer - 16'd1;
      DATA: if (bit_done) begin
        shift_d = shift >> 1;
        timer_d = bit_time(baud_div);
        if (bit_idx == 3'd7) state_d = STOP;
        else bit_idx_d = bit_idx + 3'd1;
      end else timer_d = timer - 16'd1;
      STOP: if (bit_done) state_d = IDLE;
      else timer_d = timer - 16'd1;
      default: state_d = IDLE;
    endcase
  end

  // tx and the irq are registered from next-state values so they align with state.
  always_comb begin
    busy       = (state != IDLE);
    count_next = fifo_count + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
    irq_d      = (count_next == '0) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_bus_uart_tx_peripheral.sv
// Directed bench for the bus UART transmitter: register vectors plus frame-level sequences.
module tb_bus_uart_tx_peripheral;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_empty_irq;
  int   total = 0;
  int   bad   = 0;

  bus_uart_tx_peripheral_if bus();

  bus_uart_tx_peripheral dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .tx           (tx),
    .tx_empty_irq (tx_empty_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.busSel      = 1'b1;
    bus.busWe       = 1'b1;
    bus.busAddr     = {28'h0, a, 2'b00};
    bus.busWData    = d;
    bus.Byte_Enable = be;
    @(negedge clk);
    bus.busSel = 1'b0;
    bus.busWe  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.busSel  = 1'b1;
    bus.busWe   = 1'b0;
    bus.busAddr = {28'h0, a, 2'b00};
    #1;
    d = bus.busRData;
    bus.busSel = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, tx}, 32'd0);
  endtask

  // Samples the first cycle of every bit, starting from the first low cycle.
  task automatic recv(input int div, input string name, output logic [7:0] b);
    wait_start({name, "_start"});
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = tx;
    end
    repeat (div) @(negedge clk);
    check({name, "_stop"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  rx, frame;
    logic [7:0]  exp_bytes [9];
    int          errs, k, n_low;
    logic        expb;

    vecs[0]  = '{1'b0, ADDR_STATUS, 32'h0,         4'h0, 32'h0000_0002};
    vecs[1]  = '{1'b0, ADDR_BAUD,   32'h0,         4'h0, 32'd868};
    vecs[2]  = '{1'b0, ADDR_CTRL,   32'h0,         4'h0, 32'h0};
    vecs[3]  = '{1'b0, ADDR_TXDATA, 32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b1, ADDR_BAUD,   32'hFFFF_0003, 4'b0001, 32'h0};
    vecs[5]  = '{1'b0, ADDR_BAUD,   32'h0,         4'h0, 32'h0000_0303};
    vecs[6]  = '{1'b1, ADDR_BAUD,   32'h0000_AB00, 4'b0010, 32'h0};
    vecs[7]  = '{1'b0, ADDR_BAUD,   32'h0,         4'h0, 32'h0000_AB03};
    vecs[8]  = '{1'b1, ADDR_BAUD,   32'h1234_5678, 4'b1100, 32'h0};
    vecs[9]  = '{1'b0, ADDR_BAUD,   32'h0,         4'h0, 32'h0000_AB03};
    vecs[10] = '{1'b1, ADDR_CTRL,   32'hFFFF_FFFF, 4'b1110, 32'h0};
    vecs[11] = '{1'b0, ADDR_CTRL,   32'h0,         4'h0, 32'h0};

    bus.busSel = 1'b0; bus.busWe = 1'b0; bus.busAddr = '0;
    bus.busWData = '0; bus.Byte_Enable = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, tx_empty_irq}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Single 0x55 frame at 4 clocks per bit, checked cycle by cycle.
    frame = 8'h55;
    bus_write(ADDR_BAUD, 32'd4, 4'hF);
    bus_write(ADDR_TXDATA, {24'd0, frame}, 4'b0001);
    bus_write(ADDR_CTRL, 32'd1, 4'b0001);
    wait_start("f55_start");
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      k = c / 4;
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : frame[k-1];
      if (tx !== expb) errs++;
      if (c == 20) begin
        bus_read(ADDR_STATUS, rd);
        check("f55_mid_status", rd, 32'h0000_0006);
        check("f55_mid_irq", {31'd0, tx_empty_irq}, 32'd0);
      end
      @(negedge clk);
    end
    check("f55_waveform_errs", errs, 0);
    repeat (2) @(negedge clk);
    check("f55_irq_after", {31'd0, tx_empty_irq}, 32'd1);
    bus_read(ADDR_STATUS, rd);
    check("f55_status_after", rd, 32'h0000_0002);

    // Fill with tx disabled, then overflow and clear.
    bus_write(ADDR_CTRL, 32'd0, 4'b0001);
    bus_write(ADDR_BAUD, 32'd2, 4'hF);
    for (int i = 0; i < 8; i++) begin
      exp_bytes[i] = 8'hA0 + 8'(i);
      bus_write(ADDR_TXDATA, {24'd0, exp_bytes[i]}, 4'b0001);
    end
    bus_read(ADDR_STATUS, rd);
    check("fill8_status", rd, 32'h0000_0801);
    bus_write(ADDR_TXDATA, 32'h0000_003C, 4'b0001);
    bus_read(ADDR_STATUS, rd);
    check("overflow_status", rd, 32'h0000_0809);
    bus_write(ADDR_STATUS, 32'h0000_0008, 4'b0001);
    bus_read(ADDR_STATUS, rd);
    check("ovf_clear_status", rd, 32'h0000_0801);

    // Enable, then push in exactly the cycle of the first pop.
    exp_bytes[8] = 8'h5A;
    bus_write(ADDR_CTRL, 32'd1, 4'b0001);
    bus_write(ADDR_TXDATA, {24'd0, exp_bytes[8]}, 4'b0001);
    bus_read(ADDR_STATUS, rd);
    check("push_on_pop_status", rd, 32'h0000_0805);
    for (int i = 0; i < 9; i++) begin
      recv(2, $sformatf("drain%0d", i), rx);
      check($sformatf("drain%0d_byte", i), {24'd0, rx}, {24'd0, exp_bytes[i]});
    end

    // Divisor zero behaves as one clock per bit.
    bus_write(ADDR_BAUD, 32'd0, 4'hF);
    bus_read(ADDR_BAUD, rd);
    check("baud_zero_read", rd, 32'd0);
    bus_write(ADDR_TXDATA, 32'h0000_0096, 4'b0001);
    recv(1, "div0", rx);
    check("div0_byte", {24'd0, rx}, 32'h0000_0096);

    // Reset in the middle of data bit 3.
    repeat (6) @(negedge clk);
    bus_write(ADDR_CTRL, 32'd0, 4'b0001);
    bus_write(ADDR_BAUD, 32'd4, 4'hF);
    bus_write(ADDR_TXDATA, 32'h11, 4'b0001);
    bus_write(ADDR_TXDATA, 32'h22, 4'b0001);
    bus_write(ADDR_TXDATA, 32'h33, 4'b0001);
    bus_write(ADDR_CTRL, 32'd1, 4'b0001);
    wait_start("rst_frame_start");
    repeat (17) @(negedge clk);
    bus_read(ADDR_STATUS, rd);
    check("pre_reset_status", rd, 32'h0000_0204);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_irq", {31'd0, tx_empty_irq}, 32'd1);
    bus_read(ADDR_STATUS, rd);
    check("rst_mid_status", rd, 32'h0000_0002);
    reset = 1'b0;
    bus_write(ADDR_CTRL, 32'd1, 4'b0001);
    n_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) n_low++;
    end
    check("rst_flushed_line_low_cycles", n_low, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
